// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_prio_enc4.sv
// Round-robin winner search: scans ptr+1, ptr+2, ptr+3, ptr and picks the first set request.
module rr_prio_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // 2-bit addition wraps modulo 4, giving the rotating scan order
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!any && req[ptr + ID_W'(i)]) begin
        idx = ptr + ID_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with registered one-hot grant and optional hold-time limit.
module rr_arb4_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t             state, state_nx;
  logic [N_REQ-1:0]   grant_nx;
  logic [ID_W-1:0]    id_nx, ptr, ptr_nx, win;
  logic [HOLD_W-1:0]  hold, hold_nx;
  logic               to_nx, any, cut, norm;

  rr_prio_enc4 u_enc (
    .req (req),
    .ptr (ptr),
    .idx (win),
    .any (any)
  );

  assign gnt_valid = |grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      gnt_id  <= '0;
      timeout <= 1'b0;
      hold    <= '0;
      ptr     <= ID_W'(N_REQ - 1);
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      gnt_id  <= id_nx;
      timeout <= to_nx;
      hold    <= hold_nx;
      ptr     <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    id_nx    = gnt_id;
    ptr_nx   = ptr;
    hold_nx  = hold;
    to_nx    = 1'b0;
    cut      = 1'b0;
    norm     = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_nx = BUSY;
          grant_nx = N_REQ'(1) << win;
          id_nx    = win;
          ptr_nx   = win;
          hold_nx  = '0;
        end
      end
      BUSY: begin
        cut  = (MAX_HOLD != 0) && (hold == HOLD_LIM);
        norm = done || !req[gnt_id];
        if (norm || cut) begin
          state_nx = IDLE;
          grant_nx = '0;
          id_nx    = '0;
          // a normal release in the same cycle as the limit wins: no pulse
          to_nx    = cut && !norm;
        end else if (hold != HOLD_SAT) begin
          hold_nx = hold + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Directed and randomized checks of rr_arb4_ctrl against a behavioural arbiter model.
module tb_rr_arb4_ctrl;

  localparam int MAXH = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // model: owner is -1 when nobody holds the grant
  int m_owner, m_ptr, m_hold;
  bit m_to;

  rr_arb4_ctrl #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] r, input logic d);
    bit lim;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && r[c]) begin
          m_owner = c;
          m_ptr   = c;
          m_hold  = 0;
        end
      end
    end else begin
      lim = (MAXH != 0) && (m_hold == MAXH - 1);
      if (d || !r[m_owner] || lim) begin
        m_to    = lim && !d && r[m_owner];
        m_owner = -1;
      end else if (m_hold < 15) begin
        m_hold++;
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".grant"},   grant,     (m_owner < 0) ? 0 : (1 << m_owner));
    check({tag, ".gnt_id"},  gnt_id,    (m_owner < 0) ? 0 : m_owner);
    check({tag, ".valid"},   gnt_valid, (m_owner < 0) ? 0 : 1);
    check({tag, ".timeout"}, timeout,   m_to);
  endtask

  // called one time unit after a rising edge; returns one unit after the next
  task automatic step(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    compare_model("cyc");
  endtask

  // asserts reset between edges and checks outputs clear before any clock
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("rst.grant",   grant,     0);
    check("rst.gnt_id",  gnt_id,    0);
    check("rst.valid",   gnt_valid, 0);
    check("rst.timeout", timeout,   0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [$];
    logic [3:0] r;
    logic       d;
    int         cnt;

    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // single requester, first arbitration after reset
    step(4'b0001, 1'b0);
    check("t29.grant", grant, 4'b0001);
    check("t29.id",    gnt_id, 0);
    check("t29.valid", gnt_valid, 1);

    // full request rotation with done on each grant
    step(4'b0000, 1'b0);
    apply_reset();
    for (int c = 0; c < 60 && seq.size() < 5; c++) begin
      step(4'hF, m_owner >= 0);
      if (grant != 4'b0000) seq.push_back(grant);
    end
    check("t30.count", seq.size(), 5);
    if (seq.size() == 5) begin
      check("t30.g0", seq[0], 4'b0001);
      check("t30.g1", seq[1], 4'b0010);
      check("t30.g2", seq[2], 4'b0100);
      check("t30.g3", seq[3], 4'b1000);
      check("t30.g4", seq[4], 4'b0001);
    end

    // hold limit timeout
    apply_reset();
    step(4'b0100, 1'b0);
    cnt = 0;
    while (grant == 4'b0100 && cnt < 40) begin
      cnt++;
      step(4'b0100, 1'b0);
    end
    check("t31.cycles",  cnt, 15);
    check("t31.grant",   grant, 4'b0000);
    check("t31.timeout", timeout, 1);
    step(4'b0100, 1'b0);
    check("t31.pulse1",  timeout, 0);

    // done coinciding with the hold limit
    apply_reset();
    step(4'b0100, 1'b0);
    for (int i = 0; i < 14; i++) step(4'b0100, 1'b0);
    check("t32.held", grant, 4'b0100);
    step(4'b0100, 1'b1);
    check("t32.grant",   grant, 4'b0000);
    check("t32.timeout", timeout, 0);

    // request drop mid-BUSY
    apply_reset();
    step(4'b0100, 1'b0);
    step(4'b0110, 1'b0);
    check("t32.other", grant, 4'b0100);
    step(4'b0010, 1'b0);
    check("t32.drop",  grant, 4'b0000);

    // asynchronous reset during BUSY, then search from ptr=3
    apply_reset();
    step(4'b0010, 1'b0);
    check("t33.busy", grant, 4'b0010);
    apply_reset();
    step(4'b1000, 1'b0);
    check("t33.grant", grant, 4'b1000);
    check("t33.id",    gnt_id, 3);

    // randomized traffic
    r = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 249) == 0) apply_reset();
      step(r, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arb4_ctrl.md
RR_ARB4_CTRL -- requirements
Module: rr_arb4_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of BUSY cycles per grant; 0 disables the timeout.
REQ-002 SHALL have parameter HOLD_W, default 4, meaning the hold-counter width; MAX_HOLD SHALL fit in HOLD_W bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 4 bits: request per requester; bit k belongs to requester k.
REQ-006 SHALL have port done, input, 1 bit: the granted requester finished its access; ignored outside BUSY.
REQ-007 SHALL have port grant, output, 4 bits: one-hot grant, registered.
REQ-008 SHALL have port gnt_id, output, 2 bits: binary index of the granted requester, registered.
REQ-009 SHALL have port gnt_valid, output, 1 bit: high exactly when grant is nonzero.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 SHALL implement states IDLE and BUSY.
REQ-012 IDLE, req==0: SHALL stay in IDLE; grant=0, gnt_valid=0.
REQ-013 IDLE, req!=0 at edge N: SHALL choose a winner and go to BUSY at edge N, so grant/gnt_id/gnt_valid are visible in cycle N+1 (1-cycle latency).
REQ-014 Winner search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4); the first set req bit wins.
REQ-015 On entering BUSY, SHALL set ptr to the winner index and clear the hold counter to 0.
REQ-016 BUSY: grant SHALL stay constant; hold counter SHALL increment by 1 each cycle, saturating at 2^HOLD_W-1.
REQ-017 BUSY release conditions: done=1; or req[gnt_id]=0; or (MAX_HOLD!=0 and hold counter==MAX_HOLD-1).
REQ-018 On a release at edge M, SHALL go to IDLE; grant=0 and gnt_valid=0 from cycle M+1.
REQ-019 After every release, SHALL spend at least one IDLE cycle before the next grant.
REQ-020 timeout SHALL pulse in cycle M+1 only when the hold limit alone caused the release.
REQ-021 If done or a req drop occurs in the same cycle as the hold limit, SHALL treat it as a normal release with no timeout pulse.
REQ-022 Changes to other req bits during BUSY SHALL NOT affect the current grant.
REQ-023 gnt_id SHALL equal the encoded index of grant whenever gnt_valid=1, and SHALL be 0 otherwise.

Reset
REQ-024 rst asserted SHALL immediately force state=IDLE, grant=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0, ptr=3 (so requester 0 has first priority).
REQ-025 rst asserted during BUSY SHALL drop grant within the same cycle, without waiting for a clock edge.
REQ-026 After rst deasserts, the first arbitration SHALL occur at the first rising clk edge where req!=0.

Structure
REQ-027 Shared package arb_pkg SHALL hold the state enum (IDLE, BUSY), N_REQ=4, and ID_W=2.
REQ-028 The winner search SHALL be a combinational sub-module rr_prio_enc4 (inputs: req, ptr; outputs: idx, any); all other logic SHALL stay in rr_arb4_ctrl.

Verification
REQ-029 Reset then req=0001 -> next cycle grant=0001, gnt_id=0, gnt_valid=1.
REQ-030 req=1111 held, done pulsed once per grant -> grants in order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
REQ-031 MAX_HOLD=15, req=0100 held, done=0 -> grant=0100 for exactly 15 cycles, then grant=0 and timeout=1 for exactly one cycle.
REQ-032 done and the hold limit in the same cycle -> release with timeout=0; also, req[gnt_id] dropped mid-BUSY -> grant=0 next cycle.
REQ-033 rst asserted mid-BUSY between clock edges -> grant=0 immediately; after release, req=1000 -> grant=1000 (ptr=3 search order 0, 1, 2, 3).
